// File: rtl/event_toggle_logger.sv
// event_toggle_logger: turns each level change of an upstream toggle flag into
// a one-cycle pulse, keeps saturating event and drop counters, and queues a
// timestamp per event in a first-word-fall-through FIFO.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   toggle_in    upstream event flag; every level change is one event
//   clear        synchronous clear of counters, sticky flag and FIFO
//   evt_pulse    one-cycle pulse per detected event
//   event_count  saturating count of detected events
//   drop_count   saturating count of events lost to a full FIFO
//   overflow     sticky, set on the first dropped event
//   rec_valid    FIFO non-empty
//   rec_ready    consumer accepts the head record
//   rec_ts       timestamp of the head record
//   fifo_level   current FIFO occupancy
module event_toggle_logger #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned TS_W  = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     toggle_in,
  input  logic                     clear,
  output logic                     evt_pulse,
  output logic [CNT_W-1:0]         event_count,
  output logic [CNT_W-1:0]         drop_count,
  output logic                     overflow,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [TS_W-1:0]          rec_ts,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic            toggle_q;
  logic [TS_W-1:0] ts;
  logic [TS_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  logic            det_c;
  logic            pop_c;
  logic            full_c;
  logic            push_c;
  logic            drop_c;
  logic [AW-1:0]   rd_nxt_c;
  logic [LW-1:0]   lvl_nxt_c;
  logic [TS_W-1:0] head_nxt_c;

  // Event detection, FIFO push/pop decisions and next head record.
  always_comb begin
    det_c      = (toggle_in != toggle_q) && !clear;
    pop_c      = rec_valid && rec_ready;
    full_c     = (fifo_level == LW'(DEPTH));
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    push_c     = det_c && (!full_c || pop_c);
    drop_c     = det_c && full_c && !pop_c;
    rd_nxt_c   = rd_ptr + AW'(pop_c);
    lvl_nxt_c  = fifo_level + LW'(push_c) - LW'(pop_c);
    head_nxt_c = mem[rd_nxt_c];
    // FIFO empty after the pop: the pushed record becomes the head directly.
    if (push_c && (fifo_level == LW'(pop_c))) begin
      head_nxt_c = ts;
    end
    if (lvl_nxt_c == '0) begin
      head_nxt_c = '0;
    end
  end

  // Free-running timestamp and toggle sampling; neither is affected by clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts       <= '0;
      toggle_q <= 1'b0;
    end else begin
      ts       <= ts + TS_W'(1);
      toggle_q <= toggle_in;
    end
  end

  // Record storage; contents are only observed through valid pointers.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= ts;
    end
  end

  // Counters, sticky flag, FIFO pointers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_pulse   <= 1'b0;
      event_count <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
      rec_valid   <= 1'b0;
      rec_ts      <= '0;
      fifo_level  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else if (clear) begin
      evt_pulse   <= 1'b0;
      event_count <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
      rec_valid   <= 1'b0;
      rec_ts      <= '0;
      fifo_level  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      evt_pulse <= det_c;
      if (det_c && (event_count != '1)) begin
        event_count <= event_count + CNT_W'(1);
      end
      if (drop_c) begin
        overflow <= 1'b1;
        if (drop_count != '1) begin
          drop_count <= drop_count + CNT_W'(1);
        end
      end
      if (push_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr     <= rd_nxt_c;
      fifo_level <= lvl_nxt_c;
      rec_valid  <= (lvl_nxt_c != '0);
      rec_ts     <= head_nxt_c;
    end
  end

endmodule

// File: tb/tb_event_toggle_logger.sv
// Testbench for event_toggle_logger (CNT_W = 4 build to reach saturation).
// Stimulus pushes expected record timestamps into a queue; a monitor pops and
// compares whenever the DUT hands over a record.
module tb_event_toggle_logger;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned TS_W  = 16;
  localparam int unsigned DEPTH = 4;

  logic             clk;
  logic             rst_n;
  logic             toggle_in;
  logic             clear;
  logic             evt_pulse;
  logic [CNT_W-1:0] event_count;
  logic [CNT_W-1:0] drop_count;
  logic             overflow;
  logic             rec_valid;
  logic             rec_ready;
  logic [TS_W-1:0]  rec_ts;
  logic [2:0]       fifo_level;

  int checks = 0;
  int errors = 0;

  logic [TS_W-1:0] exp_q[$];
  logic [TS_W-1:0] edge_cnt;

  event_toggle_logger #(.CNT_W(CNT_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .toggle_in   (toggle_in),
    .clear       (clear),
    .evt_pulse   (evt_pulse),
    .event_count (event_count),
    .drop_count  (drop_count),
    .overflow    (overflow),
    .rec_valid   (rec_valid),
    .rec_ready   (rec_ready),
    .rec_ts      (rec_ts),
    .fifo_level  (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release: the timestamp a record sampled now should carry.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= '0;
    else        edge_cnt <= edge_cnt + 16'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // Record monitor: a transfer happens at the next edge when valid && ready.
  always @(negedge clk) begin
    if (rst_n && rec_valid && rec_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rec_unexpected got ts %0d expected no record", rec_ts);
      end else begin
        check("rec_ts_pop", 32'(rec_ts), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic flip(input bit expect_push);
    if (expect_push) exp_q.push_back(edge_cnt);
    toggle_in = ~toggle_in;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; toggle_in = 1'b0; clear = 1'b0; rec_ready = 1'b0;
    tick(); tick();
    check("rst_pulse", 32'(evt_pulse), 32'd0);
    check("rst_count", 32'(event_count), 32'd0);
    check("rst_valid", 32'(rec_valid), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ts", 32'(rec_ts), 32'd0);

    // First event sampled on the 3rd edge after release carries ts = 2.
    rst_n = 1'b1;
    tick(); tick();
    flip(1'b1);
    check("t1_pulse", 32'(evt_pulse), 32'd1);
    check("t1_count", 32'(event_count), 32'd1);
    check("t1_valid", 32'(rec_valid), 32'd1);
    check("t1_level", 32'(fifo_level), 32'd1);
    check("t1_ts", 32'(rec_ts), 32'd2);
    tick();
    check("t1_pulse_end", 32'(evt_pulse), 32'd0);
    check("t1_ovf", 32'(overflow), 32'd0);

    // Five back-to-back events into an empty FIFO with no consumer.
    clear = 1'b1; tick(); clear = 1'b0; exp_q.delete();
    check("clr_count", 32'(event_count), 32'd0);
    check("clr_valid", 32'(rec_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      flip(i < 4);
      check("t2_pulse", 32'(evt_pulse), 32'd1);
    end
    check("t2_count", 32'(event_count), 32'd5);
    check("t2_level", 32'(fifo_level), 32'd4);
    check("t2_drop", 32'(drop_count), 32'd1);
    check("t2_ovf", 32'(overflow), 32'd1);
    check("t2_head", 32'(rec_ts), 32'(exp_q[0]));

    // Full FIFO: pop and push on the same edge, nothing dropped.
    rec_ready = 1'b1;
    flip(1'b1);
    rec_ready = 1'b0;
    check("t3_level", 32'(fifo_level), 32'd4);
    check("t3_drop", 32'(drop_count), 32'd1);
    check("t3_ovf", 32'(overflow), 32'd1);
    check("t3_head", 32'(rec_ts), 32'(exp_q[0]));
    check("t3_count", 32'(event_count), 32'd6);

    // clear on the same edge as an event wins; the next event counts as 1.
    toggle_in = ~toggle_in; clear = 1'b1;
    tick();
    clear = 1'b0; exp_q.delete();
    check("t4_count", 32'(event_count), 32'd0);
    check("t4_level", 32'(fifo_level), 32'd0);
    check("t4_pulse", 32'(evt_pulse), 32'd0);
    check("t4_drop", 32'(drop_count), 32'd0);
    check("t4_ovf", 32'(overflow), 32'd0);
    flip(1'b1);
    check("t4_count_next", 32'(event_count), 32'd1);
    check("t4_pulse_next", 32'(evt_pulse), 32'd1);
    check("t4_level_next", 32'(fifo_level), 32'd1);
    tick();
    check("t4_no_spurious", 32'(evt_pulse), 32'd0);
    rec_ready = 1'b1; tick(); rec_ready = 1'b0;
    check("t4_drained", 32'(rec_valid), 32'd0);

    // Saturate the 4-bit event counter while records keep flowing.
    rec_ready = 1'b1;
    for (int i = 0; i < 14; i++) flip(1'b1);
    check("t5_count_max", 32'(event_count), 32'd15);
    flip(1'b1);
    check("t5_count_sat", 32'(event_count), 32'd15);
    check("t5_valid", 32'(rec_valid), 32'd1);
    check("t5_qsize", 32'(exp_q.size()), 32'd1);
    check("t5_head", 32'(rec_ts), 32'(exp_q[0]));
    tick();
    rec_ready = 1'b0;
    check("t5_drained", 32'(rec_valid), 32'd0);

    // Asynchronous reset with three records queued, released with toggle_in = 1.
    for (int i = 0; i < 3; i++) flip(1'b1);
    check("t6_level", 32'(fifo_level), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    check("t6_valid_async", 32'(rec_valid), 32'd0);
    check("t6_level_async", 32'(fifo_level), 32'd0);
    check("t6_count_async", 32'(event_count), 32'd0);
    check("t6_ovf_async", 32'(overflow), 32'd0);
    exp_q.delete();
    toggle_in = 1'b1;
    tick();
    rst_n = 1'b1;
    exp_q.push_back(edge_cnt);
    tick();
    check("t6_pulse", 32'(evt_pulse), 32'd1);
    check("t6_count", 32'(event_count), 32'd1);
    check("t6_ts", 32'(rec_ts), 32'd0);
    tick();
    check("t6_pulse_end", 32'(evt_pulse), 32'd0);
    check("t6_count_once", 32'(event_count), 32'd1);
    check("t6_level_once", 32'(fifo_level), 32'd1);
    rec_ready = 1'b1; tick(); rec_ready = 1'b0;
    check("t6_drained", 32'(rec_valid), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
